// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external 8-bit ALU among NREQ valid/ready requesters.
// Define ALU_ARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index-wins priority.
module alu_arbiter #(
    parameter int NREQ    = 4,
    parameter int ALU_LAT = 1
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [8*NREQ-1:0]   req_opA,
    input  logic [8*NREQ-1:0]   req_opB,
    input  logic [2*NREQ-1:0]   req_opcode,
    input  logic [3*NREQ-1:0]   req_shift,
    output logic [NREQ-1:0]     rsp_valid,
    input  logic [NREQ-1:0]     rsp_ready,
    output logic [7:0]          rsp_data,
    output logic [7:0]          alu_opA,
    output logic [7:0]          alu_opB,
    output logic [1:0]          alu_opcode,
    output logic [2:0]          alu_shift_num,
    input  logic [7:0]          alu_y,
    output logic                busy
);

    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(ALU_LAT + 1);
    localparam logic [CW-1:0] LAT_LOAD = CW'(ALU_LAT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [GW-1:0]   grant_reg;
    logic [GW-1:0]   grant_idx;
    logic [GW-1:0]   cand;
    logic            grant_found;
    logic            req_hs;
    logic            rsp_hs;
    logic [7:0]      opa_reg, opb_reg, rsp_data_reg;
    logic [1:0]      opcode_reg;
    logic [2:0]      shift_reg;

`ifdef ALU_ARB_FIXED_PRIO_EN
    // Descending scan so the lowest-index valid requester is the final assignment.
    always_comb begin
        grant_idx   = '0;
        cand        = '0;
        grant_found = |req_valid;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = GW'(k);
            if (req_valid[cand]) begin
                grant_idx = cand;
            end
        end
    end
`else
    logic [GW-1:0] last_grant_reg;

    always_comb begin
        grant_idx   = '0;
        grant_found = 1'b0;
        cand        = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = GW'((int'(last_grant_reg) + k) % NREQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Updated only on a completed response, so an aborted operation never moves the pointer.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            last_grant_reg <= GW'(NREQ - 1);
        end else if (rsp_hs) begin
            last_grant_reg <= grant_reg;
        end
    end
`endif

    // Gated by resetn so req_ready reads zero for the whole reset window, not just after an edge.
    assign req_hs = resetn && (state_reg == IDLE) && grant_found;
    assign rsp_hs = (state_reg == RESP) && rsp_ready[grant_reg];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_onehot
            assign req_ready[gi] = req_hs && (grant_idx == GW'(gi));
            assign rsp_valid[gi] = (state_reg == RESP) && (grant_reg == GW'(gi));
        end
    endgenerate

    assign busy          = (state_reg != IDLE);
    assign rsp_data      = rsp_data_reg;
    assign alu_opA       = opa_reg;
    assign alu_opB       = opb_reg;
    assign alu_opcode    = opcode_reg;
    assign alu_shift_num = shift_reg;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (req_hs) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                cnt_next   = LAT_LOAD;
                state_next = WAIT;
            end
            WAIT: begin
                cnt_next = cnt_reg - 1'b1;
                if (cnt_reg == CW'(1)) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_hs) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            grant_reg    <= '0;
            opa_reg      <= '0;
            opb_reg      <= '0;
            opcode_reg   <= '0;
            shift_reg    <= '0;
            rsp_data_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (req_hs) begin
                grant_reg  <= grant_idx;
                opa_reg    <= req_opA[8*grant_idx +: 8];
                opb_reg    <= req_opB[8*grant_idx +: 8];
                opcode_reg <= req_opcode[2*grant_idx +: 2];
                shift_reg  <= req_shift[3*grant_idx +: 3];
            end
            if ((state_reg == WAIT) && (cnt_reg == CW'(1))) begin
                rsp_data_reg <= alu_y;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a behavioural ALU, a grant model and a response monitor.
module tb_alu_arbiter;
    localparam int NREQ    = 4;
    localparam int ALU_LAT = 1;

    logic                clock     = 1'b0;
    logic                resetn    = 1'b0;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ-1:0]     req_ready;
    logic [8*NREQ-1:0]   req_opA, req_opB;
    logic [2*NREQ-1:0]   req_opcode;
    logic [3*NREQ-1:0]   req_shift;
    logic [NREQ-1:0]     rsp_valid;
    logic [NREQ-1:0]     rsp_ready = '0;
    logic [7:0]          rsp_data, alu_opA, alu_opB, alu_y;
    logic [1:0]          alu_opcode;
    logic [2:0]          alu_shift_num;
    logic                busy;

    logic [7:0] pa [NREQ];
    logic [7:0] pb [NREQ];
    logic [1:0] po [NREQ];
    logic [2:0] ps [NREQ];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int rsp_mode = 0;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_pack
            assign req_opA[8*gi +: 8]    = pa[gi];
            assign req_opB[8*gi +: 8]    = pb[gi];
            assign req_opcode[2*gi +: 2] = po[gi];
            assign req_shift[3*gi +: 3]  = ps[gi];
        end
    endgenerate

    alu_arbiter #(.NREQ(NREQ), .ALU_LAT(ALU_LAT)) dut (
        .clock(clock), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_opA(req_opA), .req_opB(req_opB), .req_opcode(req_opcode), .req_shift(req_shift),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .alu_opA(alu_opA), .alu_opB(alu_opB), .alu_opcode(alu_opcode),
        .alu_shift_num(alu_shift_num), .alu_y(alu_y), .busy(busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [1:0] op, input logic [2:0] sh);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a << sh;
            default: return a >> sh;
        endcase
    endfunction

    // External ALU: registered result, ALU_LAT cycles deep.
    logic [7:0] alu_pipe [ALU_LAT];
    always @(posedge clock) begin
        alu_pipe[0] <= alu_ref(alu_opA, alu_opB, alu_opcode, alu_shift_num);
        for (int k = 1; k < ALU_LAT; k++) alu_pipe[k] <= alu_pipe[k-1];
    end
    assign alu_y = alu_pipe[ALU_LAT-1];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] v, input int last);
`ifdef ALU_ARB_FIXED_PRIO_EN
        for (int k = 0; k < NREQ; k++) if (v[k]) return k;
`else
        for (int k = 1; k <= NREQ; k++) if (v[(last + k) % NREQ]) return (last + k) % NREQ;
`endif
        return -1;
    endfunction

    typedef struct {
        int         idx;
        logic [7:0] data;
        int         due;
    } exp_t;
    exp_t exp_q[$];
    int   grant_log[$];

    // Grant model: predicts req_ready/busy and pushes expected responses.
    int              m_last = NREQ - 1;
    int              m_cur  = 0;
    bit              m_idle = 1'b1;
    logic [NREQ-1:0] hs_req = '0;
    always @(negedge clock) begin
        logic [NREQ-1:0] exp_ready;
        int w;
        exp_ready = '0;
        if (!resetn) begin
            m_last = NREQ - 1;
            m_idle = 1'b1;
            hs_req = '0;
            exp_q.delete();
        end else begin
            hs_req = req_valid & req_ready;
            for (int k = 0; k < NREQ; k++) if (hs_req[k]) grant_log.push_back(k);
            if (m_idle) begin
                check("busy_idle", busy, 0);
                if (|req_valid) begin
                    w = pick(req_valid, m_last);
                    exp_ready[w] = 1'b1;
                    exp_q.push_back('{w, alu_ref(pa[w], pb[w], po[w], ps[w]), cyc + 2 + ALU_LAT});
                    m_last = w;
                    m_cur  = w;
                    m_idle = 1'b0;
                end
                check("req_ready", req_ready, exp_ready);
            end else begin
                check("req_ready_busy", req_ready, 0);
                check("busy_active", busy, 1);
                if (rsp_valid[m_cur] && rsp_ready[m_cur]) m_idle = 1'b1;
            end
        end
    end

    // Response monitor: pops the scoreboard when the DUT presents a response.
    bit         in_rsp = 1'b0;
    int         cur_idx = 0;
    logic [7:0] cur_data = '0;
    logic [7:0] last_rsp_data = '0;
    int         rsp_count = 0;
    exp_t       e;
    always @(negedge clock) begin
        if (!resetn) begin
            in_rsp = 1'b0;
        end else begin
            if (|rsp_valid) begin
                if (!in_rsp) begin
                    if (exp_q.size() == 0) begin
                        check("rsp_unexpected", rsp_valid, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_valid", rsp_valid, NREQ'(1) << e.idx);
                        check("rsp_data", rsp_data, e.data);
                        check("rsp_latency", cyc, e.due);
                        in_rsp   = 1'b1;
                        cur_idx  = e.idx;
                        cur_data = e.data;
                    end
                end else begin
                    check("rsp_hold_valid", rsp_valid, NREQ'(1) << cur_idx);
                    check("rsp_hold_data", rsp_data, cur_data);
                end
                if (in_rsp && rsp_ready[cur_idx]) begin
                    in_rsp = 1'b0;
                    last_rsp_data = rsp_data;
                    rsp_count++;
                    $display("[TB] rsp req%0d data=0x%02h cyc=%0d", cur_idx, rsp_data, cyc);
                end
            end else if (in_rsp) begin
                check("rsp_dropped", rsp_valid, NREQ'(1) << cur_idx);
                in_rsp = 1'b0;
            end
            if (!in_rsp && exp_q.size() > 0 && cyc > exp_q[0].due) begin
                check("rsp_timeout", cyc, exp_q[0].due);
                void'(exp_q.pop_front());
            end
        end
    end

    // Response-side consumer: 0 always ready, 1 random, 2 stalled.
    initial forever begin
        @(posedge clock);
        #2;
        case (rsp_mode)
            0:       rsp_ready = '1;
            1:       rsp_ready = NREQ'($urandom);
            default: rsp_ready = '0;
        endcase
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                           input logic [1:0] op, input logic [2:0] sh);
        pa[i] = a; pb[i] = b; po[i] = op; ps[i] = sh;
        req_valid[i] = 1'b1;
    endtask

    task automatic set_rand(input int i);
        set_req(i, 8'($urandom), 8'($urandom), 2'($urandom), 3'($urandom));
    endtask

    task automatic step(input int prob);
        tick();
        for (int i = 0; i < NREQ; i++) begin
            if (hs_req[i]) req_valid[i] = 1'b0;
            else if (!req_valid[i]) begin
                if ($urandom_range(0, 99) < prob) set_rand(i);
            end else if (prob > 0 && $urandom_range(0, 99) < 2) req_valid[i] = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((req_valid != 0 || !m_idle || in_rsp) && n < 100) begin
            step(0);
            n++;
        end
        check("drain_timeout", n < 100, 1);
    endtask

    task automatic do_one(input int i, input logic [7:0] a, input logic [7:0] b,
                          input logic [1:0] op, input logic [2:0] sh, output logic [7:0] data);
        int n, rc;
        set_req(i, a, b, op, sh);
        n = 0;
        tick();
        while (!hs_req[i] && n < 50) begin tick(); n++; end
        check("accept_timeout", hs_req[i], 1);
        req_valid[i] = 1'b0;
        rc = rsp_count;
        n = 0;
        while (rsp_count == rc && n < 50) begin tick(); n++; end
        check("response_timeout", n < 50, 1);
        data = last_rsp_data;
    endtask

    initial begin
        logic [7:0] d;
        int n;
        int exp_order [5];
        for (int i = 0; i < NREQ; i++) begin pa[i] = '0; pb[i] = '0; po[i] = '0; ps[i] = '0; end

        repeat (3) tick();
        check("reset_outputs", {req_ready, rsp_valid, rsp_data, alu_opA, alu_opB,
                                alu_opcode, alu_shift_num, busy}, 0);
        resetn = 1'b1;
        tick();

        rsp_mode = 0;
        do_one(0, 8'h05, 8'h03, 2'b00, 3'd0, d); check("add_05_03", d, 8'h08);
        do_one(1, 8'h03, 8'h05, 2'b01, 3'd0, d); check("sub_03_05", d, 8'hFE);
        do_one(2, 8'hFF, 8'h01, 2'b00, 3'd0, d); check("add_wrap",  d, 8'h00);
        do_one(0, 8'h96, 8'h00, 2'b10, 3'd3, d); check("shift_lr0", d, 8'hB0);
        do_one(3, 8'h96, 8'h00, 2'b11, 3'd3, d); check("shift_lr1", d, 8'h12);

        // All requesters hold req_valid; each re-presents new work once accepted.
        grant_log.delete();
        for (int i = 0; i < NREQ; i++) set_rand(i);
        n = 0;
        while (grant_log.size() < 5 && n < 100) begin
            tick();
            for (int i = 0; i < NREQ; i++) if (hs_req[i]) set_rand(i);
            n++;
        end
        req_valid = '0;
        drain();
`ifdef ALU_ARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 0, 0, 0};
`else
        exp_order = '{0, 1, 2, 3, 0};
`endif
        if (grant_log.size() < 5) check("grant_count", grant_log.size(), 5);
        else for (int k = 0; k < 5; k++) check("grant_order", grant_log[k], exp_order[k]);

        // Response backpressure while others keep requesting.
        rsp_mode = 2;
        set_rand(1); set_rand(2); set_rand(3);
        n = 0;
        while (!in_rsp && n < 30) begin step(0); n++; end
        check("stall_reached", in_rsp, 1);
        repeat (5) step(0);
        check("stall_still_pending", in_rsp, 1);
        rsp_mode = 0;
        drain();

        rsp_mode = 1;
        repeat (2000) step(30);
        rsp_mode = 0;
        req_valid = '0;
        drain();

        // Abort an operation in WAIT with an asynchronous reset.
        do_one(0, 8'h11, 8'h22, 2'b00, 3'd0, d); check("pre_reset_add", d, 8'h33);
        set_req(1, 8'h40, 8'h01, 2'b00, 3'd0);
        n = 0;
        tick();
        while (!hs_req[1] && n < 50) begin tick(); n++; end
        req_valid[1] = 1'b0;
        tick();
        set_req(0, 8'h01, 8'h01, 2'b00, 3'd0);
        set_req(2, 8'h02, 8'h02, 2'b00, 3'd0);
        #1;
        resetn = 1'b0;
        #1;
        check("async_reset_outputs", {req_ready, rsp_valid, rsp_data, alu_opA, alu_opB,
                                      alu_opcode, alu_shift_num, busy}, 0);
        tick(); tick();
        grant_log.delete();
        resetn = 1'b1;
        n = 0;
        while (grant_log.size() == 0 && n < 20) begin step(0); n++; end
        if (grant_log.size() == 0) check("post_reset_grant_seen", 0, 1);
        else check("post_reset_grant", grant_log[0], 0);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one 8-bit ALU instance (add / subtract / barrel shift, one-cycle registered result) among NREQ requesters.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- Arbitration is round-robin; one operation is in flight at a time.
- Sits between the requesting engines and the ALU. Drives the ALU operand/opcode inputs and captures the ALU result `y`.

Parameters:
- NREQ, 4, number of requesters (2..8).
- ALU_LAT, 1, clock cycles from ALU inputs being sampled to `y` being valid (≥1).

Ports:
- clock  input  1  system clock, rising edge.
- resetn  input  1  asynchronous, active-low reset.
- req_valid  input  NREQ  request valid, one bit per requester.
- req_ready  output  NREQ  request accepted, one-hot or zero.
- req_opA  input  8*NREQ  operand A; requester i uses bits [8i+7:8i].
- req_opB  input  8*NREQ  operand B, same packing.
- req_opcode  input  2*NREQ  00 add, 01 sub, 10 shift left_right=0, 11 shift left_right=1.
- req_shift  input  3*NREQ  shift amount.
- rsp_valid  output  NREQ  response valid, one-hot or zero.
- rsp_ready  input  NREQ  response accepted.
- rsp_data  output  8  result, shared by all requesters, qualified by rsp_valid.
- alu_opA  output  8  ALU operand A.
- alu_opB  output  8  ALU operand B.
- alu_opcode  output  2  ALU opcode.
- alu_shift_num  output  3  ALU shift amount.
- alu_y  input  8  ALU result.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset values: state IDLE; req_ready=0, rsp_valid=0, rsp_data=0; alu_opA/opB/opcode/shift_num=0; busy=0; last_grant=NREQ-1 so requester 0 wins first; latency counter=0.
- The FSM has four states: IDLE, ISSUE, WAIT and RESP.
- IDLE:
  - Grant `g` is computed combinationally: the first requester with req_valid, searching from last_grant+1 with modulo-NREQ wrap.
  - req_ready[g]=1 combinationally, only in IDLE and only when some req_valid is high.
  - On that handshake cycle, register the selected opA/opB/opcode/shift into hold registers, register `g`, and go to ISSUE.
  - If no req_valid is high, stay in IDLE with req_ready=0.
- ISSUE:
  - One cycle. The ALU samples the hold registers at the end of it.
  - Load counter=ALU_LAT and go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - In the cycle where counter==1, capture alu_y into rsp_data and go to RESP.
- RESP:
  - rsp_valid[g]=1 and rsp_data held stable until rsp_ready[g]=1.
  - On that handshake, clear rsp_valid, set last_grant=g and go to IDLE.
  - rsp_ready bits of other requesters are ignored.
- alu_* outputs are driven directly from the hold registers, so they stay stable from ISSUE until the next grant.
- Latency: with the request handshake in cycle T, rsp_valid rises in cycle T+2+ALU_LAT (T+3 at the default). The earliest next req_ready is the cycle after the response handshake.
- Arithmetic is 8-bit wrap-around, performed by the ALU. The arbiter does not modify the result.
- A requester dropping req_valid before it is granted is legal; it is simply not granted.
- Requests arriving while busy are not acknowledged (req_ready=0). Requesters must hold req_valid and payload.
- A requester may assert req_valid again while its own response is pending. It is only considered once the FSM is back in IDLE.
- An asynchronous reset in any state aborts the operation: the result is discarded, no rsp_valid is issued, and all reset values apply immediately.
- At most one bit of req_ready and at most one bit of rsp_valid is high in any cycle.

Optional Feature:
- Macro: ALU_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, the lowest-index valid requester always wins. last_grant is not maintained.
- Undefined: round-robin as described above.
- The interface and timing are identical in both builds.

Test Plan:
- Requester 0 only, opA=8'h05, opB=8'h03, opcode=00 → req_ready[0] in cycle T, rsp_valid[0] at T+3, rsp_data=8'h08.
- Requester 1, opA=8'h03, opB=8'h05, opcode=01 → rsp_data=8'hFE. Requester 2, opA=8'hFF, opB=8'h01, opcode=00 → rsp_data=8'h00 (wrap-around).
- All four requesters hold req_valid continuously → grants in order 0,1,2,3,0. Each rsp_valid goes to the matching index with the correct result. Under ALU_ARB_FIXED_PRIO_EN, requester 0 is granted every time.
- rsp_ready held low for 5 cycles → rsp_valid and rsp_data stay stable. Other requesters' req_ready stay 0 and busy=1 throughout.
- resetn asserted during WAIT → all outputs go to 0 immediately. After release, no stale rsp_valid appears, and the next grant goes to requester 0.
- Opcode 10 and 11 with shift=3 on opA=8'h96 → rsp_data matches the barrel-shifter golden model for left_right=0 and left_right=1 respectively.
